// File: rtl/hex_scan_display_if.sv
// hex_scan_display_if -- bus bundle for the multiplexed hex display driver.
//
// Signals (direction as seen by the display driver, i.e. the slave modport):
//   load         in   one-cycle strobe capturing data/blank_mask/lz_suppress
//   data         in   4*DIGITS nibbles, nibble k drives digit k (digit 0 = LSD)
//   blank_mask   in   DIGITS bits, bit k = 1 forces digit k dark
//   lz_suppress  in   1 enables leading-zero suppression
//   blink        in   1 requests blinking (only honoured with HEX_BLINK_EN)
//   seg_n        out  active-low segments, bit 6 = a ... bit 0 = g
//   dig_en_n     out  active-low one-cold digit enables
//   frame_done   out  one-cycle pulse on scan wrap from digit DIGITS-1 to 0
//
// master: the client that loads values and watches the display outputs.
// slave:  the display driver.
interface hex_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     blank_mask;
    logic                  lz_suppress;
    logic                  blink;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     dig_en_n;
    logic                  frame_done;

    modport master (
        output load, data, blank_mask, lz_suppress, blink,
        input  seg_n, dig_en_n, frame_done
    );

    modport slave (
        input  load, data, blank_mask, lz_suppress, blink,
        output seg_n, dig_en_n, frame_done
    );
endinterface

// File: rtl/hex_scan_display.sv
// hex_scan_display -- time-multiplexed hex display driver.
//
// Scans DIGITS common-anode digits, each enabled for CLK_DIV clocks per
// frame. New values are loaded into a pending buffer and only promoted to
// the active buffer at frame wrap, so a frame never shows mixed data.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    hex_scan_display_if.slave (load/data/blank_mask/lz_suppress/blink
//          in, seg_n/dig_en_n/frame_done out)
//
// Parameters: DIGITS (1..8), CLK_DIV (>=2) clocks per digit slot,
//             BLINK_DIV (>=1) frames per blink half-period.
//
// Optional feature: define HEX_BLINK_EN to build the blink phase logic;
// without it the blink input is ignored and digits never blink.
module hex_scan_display #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLINK_DIV = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hex_scan_display_if.slave      bus
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

    logic [TW-1:0]            tick;
    logic [DW-1:0]            dig;
    logic                     wrap;

    logic [DIGITS-1:0][3:0]   pend_data;
    logic [DIGITS-1:0]        pend_blank;
    logic                     pend_lz;
    logic [DIGITS-1:0][3:0]   act_data;
    logic [DIGITS-1:0]        act_blank;
    logic                     act_lz;

    logic                     blink_dark;
    logic [DIGITS-1:0]        dark_vec;
    logic [DIGITS-1:0]        en_next;
    logic [6:0]               seg_q;
    logic [DIGITS-1:0]        dig_en_q;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Last tick of the last digit: the scan wraps on the closing edge.
    assign wrap = (tick == TICK_LAST) && (dig == DIG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            dig  <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            dig  <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // A load coinciding with wrap bypasses pending so the new frame uses it;
    // pending is still updated so later wraps keep the same values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_blank <= '0;
            pend_lz    <= 1'b0;
            act_data   <= '0;
            act_blank  <= '0;
            act_lz     <= 1'b0;
        end else if (bus.load) begin
            pend_data  <= bus.data;
            pend_blank <= bus.blank_mask;
            pend_lz    <= bus.lz_suppress;
            if (wrap) begin
                act_data  <= bus.data;
                act_blank <= bus.blank_mask;
                act_lz    <= bus.lz_suppress;
            end
        end else if (wrap) begin
            act_data  <= pend_data;
            act_blank <= pend_blank;
            act_lz    <= pend_lz;
        end
    end

`ifdef HEX_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!bus.blink) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_dark = bus.blink & phase;
`else
    logic unused_blink;
    assign unused_blink = bus.blink;
    assign blink_dark   = 1'b0;
`endif

    // Digit k is a leading zero when it and every higher nibble are zero.
    always_comb begin
        dark_vec = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            logic nz;
            nz = 1'b0;
            for (int unsigned j = k; j < DIGITS; j++) begin
                nz = nz | (act_data[j] != 4'h0);
            end
            dark_vec[k] = act_blank[k] | (act_lz & (k != 0) & ~nz) | blink_dark;
        end
    end

    always_comb begin
        en_next = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (dig == DW'(k)) en_next[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '1;
            dig_en_q <= '1;
        end else begin
            seg_q    <= dark_vec[dig] ? 7'b1111111 : glyph(act_data[dig]);
            dig_en_q <= en_next;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dig_en_n   = dig_en_q;
    assign bus.frame_done = wrap;

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of multiplexed hex digits (1..8).
REQ-002 Parameter CLK_DIV, default 50000, sets the clk cycles each digit stays enabled per scan slot (>=2).
REQ-003 Parameter BLINK_DIV, default 25, sets the full scan frames per blink half-period (>=1).
REQ-004 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load  input  1  one-cycle strobe that captures data, blank_mask and lz_suppress.
REQ-007 data  input  4*DIGITS  nibble k is the value for digit k; digit 0 is least significant.
REQ-008 blank_mask  input  DIGITS  bit k=1 forces digit k dark.
REQ-009 lz_suppress  input  1  1 enables leading-zero suppression.
REQ-010 blink  input  1  1 requests blinking of all digits (used only with HEX_BLINK_EN).
REQ-011 seg_n  output  7  active-low segments; bit 6 = a … bit 0 = g.
REQ-012 dig_en_n  output  DIGITS  active-low one-cold digit enables.
REQ-013 frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Function
REQ-014 Glyph table (0..F) SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-015 A dark digit SHALL drive seg_n=7'b1111111 and keep its dig_en_n bit low; a scan slot is never skipped.
REQ-016 A tick counter SHALL count 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and the digit index advances.
REQ-017 The digit index SHALL advance 0,1,…,DIGITS-1,0; wrap-around asserts frame_done for exactly that cycle.
REQ-018 On load the inputs SHALL go to a pending buffer; pending copies to the active buffer only on the frame_done cycle (no tearing).
REQ-019 If load and frame_done coincide, the new load values SHALL go straight to the active buffer.
REQ-020 seg_n and dig_en_n SHALL be registered from the active buffer and digit index (one-cycle latency).
REQ-021 Digit k SHALL be dark if blank_mask[k]=1.
REQ-022 With lz_suppress=1, digit k (k>=1) SHALL be dark if it and every higher nibble are zero; digit 0 is never suppressed.
REQ-023 Multiple loads within one frame SHALL keep only the last in pending.

Reset
REQ-024 While rst_n=0: seg_n=7'b1111111, dig_en_n all ones, frame_done=0, counters, buffers and blink phase cleared.
REQ-025 After rst_n rises, tick counting SHALL start on the first clk edge and digit 0 shall appear one cycle later.
REQ-026 Reset asserted mid-frame SHALL discard pending and active data immediately.

Configuration
REQ-027 With macro HEX_BLINK_EN defined, a phase bit SHALL toggle every BLINK_DIV frames; while blink=1 and the phase bit=1, all digits are dark.
REQ-028 When blink=0, the phase counter SHALL hold at zero.
REQ-029 Without HEX_BLINK_EN, blink SHALL be ignored, no phase logic is built and digits never blink.

Verification (DIGITS=4, CLK_DIV=4, BLINK_DIV=2)
REQ-030 Reset release, no load -> dig_en_n cycles 1110,1101,1011,0111 with 4 cycles each; seg_n=0000001; frame_done every 16 cycles.
REQ-031 Load data=16'hA5F0 mid-frame -> old digits complete the frame; the next frame shows digit0 0000001, digit1 0111000, digit2 0100100, digit3 0001000.
REQ-032 Load data=16'h0007 with lz_suppress=1 -> digit0 0001111; digits 1..3 show seg_n=1111111.
REQ-033 Load with blank_mask=4'b0100 coinciding with frame_done -> digit2 is dark in the immediately starting frame.
REQ-034 HEX_BLINK_EN, blink=1 -> 2 frames lit, 2 frames dark, repeating; without the macro, always lit.
REQ-035 Assert rst_n low during digit 2 -> outputs go dark asynchronously; after release the display restarts at digit 0 showing zeros.
